// File: rtl/rx_char_assembler.sv
// -----------------------------------------------------------------------------
// rx_char_assembler
//
// Assembles one asynchronous serial character from a synchronised receive
// line. A separate bit sample counter supplies a one-cycle strobe in the
// middle of every bit period; this block advances only on those strobes.
// Framing is LSB first: start (0), 8 data bits, optional even parity, stop (1).
//
// Optional feature macro: PARITY_CHECK_EN
//   undefined : 10-bit frame, parityErr tied to 0
//   defined   : 11-bit frame with even parity, parityErr reports a mismatch
//
// Ports
//   clk          in   system clock, all state changes on the rising edge
//   rst          in   synchronous active-low reset
//   rxBit        in   synchronised serial receive line, idle high
//   shiftStrobe  in   one-cycle mid-bit sample pulse
//   dataAck      in   consumer acknowledge, only meaningful while dataValid=1
//   dataOut      out  last accepted character, held until replaced
//   dataValid    out  dataOut holds an unacknowledged character
//   frameErr     out  stop bit of the character on dataOut sampled 0
//   parityErr    out  parity mismatch on the character on dataOut
//   overrun      out  sticky: a complete character was dropped while
//                     dataValid was still set (cleared by an acknowledge)
//   busy         out  high whenever a frame is being received
// -----------------------------------------------------------------------------
module rx_char_assembler (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxBit,
    input  logic       shiftStrobe,
    input  logic       dataAck,
    output logic [7:0] dataOut,
    output logic       dataValid,
    output logic       frameErr,
    output logic       parityErr,
    output logic       overrun,
    output logic       busy
);

`ifdef PARITY_CHECK_EN
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

    state_t     state;
    state_t     state_next;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic       complete;     // stop-bit strobe: character finishes this edge
    logic       accept;       // output holding register is free (or freed now)

`ifdef PARITY_CHECK_EN
    logic       parity_bit;
    logic       parity_err_q;
`endif

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first so that no path
    // leaves it unassigned; otherwise a latch would be inferred.
    always_comb begin
        state_next = state;
        complete   = 1'b0;
        if (shiftStrobe) begin
            case (state)
                IDLE: begin
                    // A high line at the start strobe is a false start.
                    if (!rxBit) state_next = DATA;
                end
                DATA: begin
                    if (bit_cnt == 3'd7) begin
`ifdef PARITY_CHECK_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
`ifdef PARITY_CHECK_EN
                PARITY: state_next = STOP;
`endif
                STOP: begin
                    state_next = IDLE;
                    complete   = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // An acknowledge arriving on the completion cycle frees the holding
    // register in time for the new character.
    assign accept = !dataValid || dataAck;

    // ------------------------------------------------------------------------
    // State, datapath and output registers
    // ------------------------------------------------------------------------
    // NOTE: reset is synchronous, so it lives inside the clocked branch and
    // the sensitivity list holds only the clock edge. All sequential state
    // uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shift_reg <= 8'h00;
            dataOut   <= 8'h00;
            dataValid <= 1'b0;
            frameErr  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state <= state_next;

            if (shiftStrobe) begin
                if (state == IDLE && !rxBit) begin
                    bit_cnt <= 3'd0;
                end
                if (state == DATA) begin
                    // LSB first: the newest bit enters at the top and the
                    // first bit ends up in bit 0 after eight strobes.
                    shift_reg <= {rxBit, shift_reg[7:1]};
                    bit_cnt   <= bit_cnt + 3'd1;   // wraps to 0 after bit 7
                end
            end

            if (complete) begin
                if (accept) begin
                    dataOut   <= shift_reg;
                    dataValid <= 1'b1;
                    frameErr  <= ~rxBit;
                end else begin
                    overrun   <= 1'b1;
                end
            end else if (dataValid && dataAck) begin
                dataValid <= 1'b0;
                overrun   <= 1'b0;
            end
        end
    end

`ifdef PARITY_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            parity_bit   <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            if (shiftStrobe && state == PARITY) begin
                parity_bit <= rxBit;
            end
            // Even parity: data bits plus parity bit must XOR to zero.
            if (complete && accept) begin
                parity_err_q <= ^{shift_reg, parity_bit};
            end
        end
    end

    assign parityErr = parity_err_q;
`else
    assign parityErr = 1'b0;
`endif

    assign busy = (state != IDLE);

endmodule

// File: doc/rx_char_assembler.md
RX_CHAR_ASSEMBLER -- requirements
Module: rx_char_assembler

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 clk  input  1  system clock; all state changes on posedge clk.
REQ-003 rst  input  1  synchronous active-low reset, sampled on posedge clk.
REQ-004 rxBit  input  1  synchronised serial receive line; idle high.
REQ-005 shiftStrobe  input  1  one-cycle mid-bit sample pulse from the bit sample counter's SROut.
REQ-006 dataAck  input  1  consumer acknowledge; meaningful only while dataValid=1.
REQ-007 dataOut  output  8  last accepted character, held until replaced.
REQ-008 dataValid  output  1  dataOut holds an unacknowledged character.
REQ-009 frameErr  output  1  stop bit of the character on dataOut sampled 0.
REQ-010 parityErr  output  1  parity mismatch on the character on dataOut; constant 0 without PARITY_CHECK_EN.
REQ-011 overrun  output  1  sticky; a complete character was discarded because dataValid was still set.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 The state machine SHALL use states IDLE, DATA, PARITY (PARITY_CHECK_EN only) and STOP; transitions occur only on cycles with shiftStrobe=1.
REQ-014 IDLE: shiftStrobe with rxBit=0 SHALL go to DATA with bitCnt=0; shiftStrobe with rxBit=1 (false start) SHALL stay in IDLE with no other state change.
REQ-015 DATA: each shiftStrobe SHALL right-shift rxBit into the MSB of an 8-bit shift register (LSB-first framing) and increment a 3-bit bitCnt.
REQ-016 On the strobe that captures data bit 7 (bitCnt=7), bitCnt SHALL wrap to 0 and the next state SHALL be PARITY if enabled, else STOP.
REQ-017 STOP: on shiftStrobe the character SHALL complete and the state SHALL return to IDLE in the same edge.
REQ-018 Completion with dataValid=0, or with dataValid=1 and dataAck=1 in the same cycle: dataOut<=shift register, dataValid<=1, frameErr<=~rxBit, parityErr<=computed result; overrun unchanged.
REQ-019 Completion with dataValid=1 and dataAck=0: dataOut, frameErr and parityErr SHALL be unchanged and overrun<=1.
REQ-020 Latency: dataValid SHALL be observed high on the cycle after the stop-bit strobe edge.
REQ-021 dataAck=1 while dataValid=1 with no completion in that cycle SHALL clear dataValid and overrun on the next edge; frameErr, parityErr and dataOut are held.
REQ-022 dataAck while dataValid=0 SHALL be ignored.
REQ-023 Cycles without shiftStrobe SHALL leave the state, bitCnt and shift register unchanged regardless of rxBit.

Reset
REQ-024 rst=0 at a posedge SHALL force the state to IDLE and bitCnt, the shift register, dataOut, dataValid, frameErr, parityErr, overrun and busy to 0, including mid-frame; the partial character is discarded.
REQ-025 rst=0 SHALL take priority over shiftStrobe and dataAck in the same cycle.

Configuration
REQ-026 Macro PARITY_CHECK_EN: when defined, the frame SHALL be 11 bits (start, 8 data, even parity, stop); the PARITY state samples the parity bit on one strobe, and parityErr = XOR of the 8 data bits and the parity bit, registered at completion per REQ-018.
REQ-027 Without PARITY_CHECK_EN the frame SHALL be 10 bits, the PARITY state SHALL not exist, and parityErr SHALL be tied to 0.

Verification
REQ-028 Reset, then frame 0x55 (start 0, bits 1,0,1,0,1,0,1,0, stop 1) with strobes 16 clk apart -> dataOut=0x55, dataValid=1, frameErr=0 one cycle after the stop strobe; busy=0.
REQ-029 rxBit=1 at the first strobe -> busy stays 0 and dataValid stays 0; the following valid frame 0x3C -> dataOut=0x3C.
REQ-030 Frame 0xA3 with stop bit 0 -> dataOut=0xA3, dataValid=1, frameErr=1.
REQ-031 Frames 0x12 then 0x34, no ack -> dataOut=0x12, overrun=1; dataAck pulse -> dataValid=0, overrun=0; ack on the exact 0x56 completion cycle -> dataOut=0x56, dataValid=1, overrun=0.
REQ-032 rst=0 after 4 data bits of a frame -> all outputs 0, busy=0; the next full frame 0x0F -> dataOut=0x0F, frameErr=0.
REQ-033 With PARITY_CHECK_EN: 0x07 with parity bit 0 -> parityErr=1; 0x07 with parity bit 1 -> parityErr=0; without the macro, the 10-bit frame 0x07 -> parityErr=0.
